td4_program_store: RTL



---
 rtl/td4_pkg.sv | 25 ++
 rtl/td4_prog_mem.sv | 36 +++
 rtl/td4_program_store.sv | 117 +++++++++++
 3 files changed

// File: rtl/td4_pkg.sv
// td4_pkg: shared definitions for the TD4 program store.
//   - controller state encoding
//   - default address / data widths
//   - instruction field slice positions and the NOP encoding
package td4_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 4;
    localparam int unsigned DATA_W_DEFAULT = 8;

    // Field positions for the default 8-bit instruction word.
    localparam int unsigned OPC_MSB = DATA_W_DEFAULT - 1;
    localparam int unsigned OPC_LSB = DATA_W_DEFAULT / 2;
    localparam int unsigned IMM_MSB = DATA_W_DEFAULT / 2 - 1;
    localparam int unsigned IMM_LSB = 0;

    // ADD A,0: opcode 0000, immediate 0.
    localparam logic [DATA_W_DEFAULT-1:0] NOP = 8'h00;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2
    } state_e;

endpackage

// File: rtl/td4_prog_mem.sv
// td4_prog_mem: 2**ADDR_W x DATA_W flop array.
//   clk, rst_n : clock, async active-low reset (clears every word)
//   we, waddr, wdata : synchronous write port
//   raddr, rdata     : combinational read port
module td4_prog_mem
    import td4_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/td4_program_store.sv
// td4_program_store: instruction supply for the TD4 core.
// Loads a program image byte-serially (valid/ready), then fetches mem[pc]
// into a registered instruction word while gating the core with cpu_run.
//   clk, rst_n            : clock, async active-low reset
//   load_en               : level request for load mode
//   start                 : begin execution from idle
//   load_valid/load_data  : byte stream in; load_ready accepts
//   load_done             : one-cycle pulse after the last address is written
//   wr_addr_o             : next write address (debug)
//   pc                    : fetch address from the core
//   opcode/immediate      : registered halves of mem[pc]
//   cpu_run               : high only while running
module td4_program_store
    import td4_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_en,
    input  logic                start,
    input  logic                load_valid,
    input  logic [DATA_W-1:0]   load_data,
    output logic                load_ready,
    output logic                load_done,
    output logic [ADDR_W-1:0]   wr_addr_o,
    input  logic [ADDR_W-1:0]   pc,
    output logic [DATA_W/2-1:0] opcode,
    output logic [DATA_W/2-1:0] immediate,
    output logic                cpu_run
);

    localparam int unsigned HALF = DATA_W / 2;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              load_done_q, load_done_d;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    td4_prog_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (wr_addr_q),
        .wdata (load_data),
        .raddr (pc),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        load_done_d = 1'b0;
        mem_we      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_en) begin
                    state_d   = StLoad;
                    wr_addr_d = '0;
                end else if (start) begin
                    state_d = StRun;
                end
            end
            StLoad: begin
                // Dropping load_en aborts; any byte offered that cycle is discarded.
                if (!load_en) begin
                    state_d = StIdle;
                end else if (load_valid) begin
                    mem_we    = 1'b1;
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                    if (&wr_addr_q) begin
                        state_d     = StRun;
                        load_done_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (load_en) begin
                    state_d   = StLoad;
                    wr_addr_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Fetch only while staying in run; every other case parks the word at NOP.
    assign instr_d = (state_q == StRun && state_d == StRun) ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wr_addr_q   <= '0;
            instr_q     <= '0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            instr_q     <= instr_d;
            load_done_q <= load_done_d;
        end
    end

    assign load_ready = (state_q == StLoad) && load_en;
    assign load_done  = load_done_q;
    assign wr_addr_o  = wr_addr_q;
    assign opcode     = instr_q[DATA_W-1:HALF];
    assign immediate  = instr_q[HALF-1:0];
    assign cpu_run    = (state_q == StRun);

endmodule
